// File: rtl/zbus_master_seq.sv
// ZX-BUS master sequencer: arbitrates two requesters and runs the bus-request,
// muxed-address and strobe handshake. Define ZBM_RR_EN for round-robin arbitration.
module zbus_master_seq #(
  parameter int ADDR_CYC   = 2,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 16,
  parameter int TMO_CYC    = 4096
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        io0,
  input  logic        io1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [7:0]  rdata,
  input  logic        busak_n,
  output logic        fbusrq_n,
  output logic [7:0]  fa,
  output logic        fa_sel,
  output logic        frd_n,
  output logic        fwr_n,
  output logic        fmrq_n,
  output logic        fiorq_n,
  output logic        forq_n,
  output logic [7:0]  fd_o,
  output logic        fd_oe,
  input  logic [7:0]  fd_i,
  output logic        owner
);

  typedef enum logic [2:0] {
    S_IDLE, S_BUSRQ, S_ADDR_H, S_ADDR_L, S_STROBE, S_RECOVER, S_HOLD, S_RELEASE
  } state_t;

  localparam logic [15:0] ADDR_LAST = 16'(ADDR_CYC - 1);
  localparam logic [15:0] STRB_LAST = 16'(STROBE_CYC - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TMO_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q, rdata_q, rdata_d;
  logic        owner_q, we_q, io_q;
  logic        lost_q, lost_d;
  logic        bak_m_q, bak_s_q;
  logic        ld, ack_c, err_c;
  logic        tie, win, other_req;

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      bak_m_q <= 1'b1;
      bak_s_q <= 1'b1;
    end else begin
      bak_m_q <= busak_n;
      bak_s_q <= bak_m_q;
    end
  end

`ifdef ZBM_RR_EN
  logic rr_q;
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst)        rr_q <= 1'b0;
    else if (ack_c) rr_q <= ~owner_q;
  end
  // In RECOVER the pointer is about to flip, so the tie goes to the other side now.
  assign tie = (state_q == S_RECOVER) ? ~owner_q : rr_q;
`else
  assign tie = 1'b0;
`endif

  assign win       = (req0 & req1) ? tie : req1;
  assign other_req = owner_q ? req0 : req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    rdata_d = rdata_q;
    ld      = 1'b0;
    ack_c   = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      S_IDLE: if (req0 | req1) begin
        ld = 1'b1; cnt_d = '0; state_d = S_BUSRQ;
      end
      S_BUSRQ: begin
        if (!bak_s_q) begin
          lost_d = 1'b0; state_d = S_ADDR_H;
        end else if (cnt_q == TMO_LAST) begin
          ack_c = 1'b1; err_c = 1'b1; state_d = S_RELEASE;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_ADDR_H: begin
        lost_d = lost_q | bak_s_q; cnt_d = '0; state_d = S_ADDR_L;
      end
      S_ADDR_L: begin
        lost_d = lost_q | bak_s_q;
        if (cnt_q == ADDR_LAST) begin
          cnt_d = '0; state_d = S_STROBE;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_STROBE: begin
        lost_d = lost_q | bak_s_q;
        if (cnt_q == STRB_LAST) begin
          if (!we_q) rdata_d = fd_i;
          state_d = S_RECOVER;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_RECOVER: begin
        ack_c = 1'b1;
        err_c = lost_q | bak_s_q;
        if (err_c) state_d = S_RELEASE;
        else if (other_req) begin
          ld = 1'b1; lost_d = 1'b0; state_d = S_ADDR_H;
        end else begin
          cnt_d = '0; state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (req0 | req1) begin
          ld = 1'b1; lost_d = 1'b0; state_d = S_ADDR_H;
        end else if (cnt_q == HOLD_LAST) state_d = S_RELEASE;
        else cnt_d = cnt_q + 16'd1;
      end
      S_RELEASE: if (bak_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
      rdata_q <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      rdata_q <= rdata_d;
      if (ld) begin
        owner_q <= win;
        we_q    <= win ? we1 : we0;
        io_q    <= win ? io1 : io0;
        addr_q  <= win ? addr1 : addr0;
        wdata_q <= win ? wdata1 : wdata0;
      end
    end
  end

  // Outputs decode registered state only, so reset clears them asynchronously.
  logic in_data, stb, drv;
  assign in_data  = (state_q == S_ADDR_L) || (state_q == S_STROBE) || (state_q == S_RECOVER);
  assign stb      = (state_q == S_STROBE) && !lost_q && !bak_s_q;
  assign drv      = in_data && we_q;

  assign fbusrq_n = (state_q == S_IDLE) || (state_q == S_RELEASE);
  assign fa_sel   = (state_q == S_ADDR_H);
  assign fa       = fa_sel ? addr_q[15:8] : (in_data ? addr_q[7:0] : 8'h00);
  assign fmrq_n   = ~(stb & ~io_q);
  assign fiorq_n  = ~(stb & io_q);
  assign frd_n    = ~(stb & ~we_q);
  assign fwr_n    = ~(stb & we_q);
  assign forq_n   = ~drv;
  assign fd_oe    = drv;
  assign fd_o     = drv ? wdata_q : 8'h00;
  assign ack0     = ack_c & ~owner_q;
  assign ack1     = ack_c & owner_q;
  assign err      = err_c;
  assign rdata    = rdata_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_zbus_master_seq.sv
// Scoreboard bench for zbus_master_seq: requester stimulus pushes expectations,
// a bus monitor captures the ZX-BUS cycle and checks each ack against them.
module tb_zbus_master_seq;
  localparam int ADDR_CYC = 2, STROBE_CYC = 8, HOLD_CYC = 16, TMO_CYC = 16;
`ifdef ZBM_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic        we, io, err;
    logic [7:0]  wd, rd;
  } exp_t;

  logic clk50 = 1'b0, rst = 1'b1;
  logic [1:0] req_v = '0, we_v = '0, io_v = '0;
  logic [15:0] addr_v [2];
  logic [7:0]  wd_v [2];
  logic ack0, ack1, err, fbusrq_n, fa_sel, frd_n, fwr_n, fmrq_n, fiorq_n, forq_n, fd_oe, owner;
  logic [7:0] rdata, fa, fd_o, fd_i;
  logic busak_n = 1'b1;

  zbus_master_seq #(.ADDR_CYC(ADDR_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC),
                    .TMO_CYC(TMO_CYC)) dut (
    .clk50(clk50), .rst(rst),
    .req0(req_v[0]), .req1(req_v[1]), .we0(we_v[0]), .we1(we_v[1]), .io0(io_v[0]), .io1(io_v[1]),
    .addr0(addr_v[0]), .addr1(addr_v[1]), .wdata0(wd_v[0]), .wdata1(wd_v[1]),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busak_n(busak_n),
    .fbusrq_n(fbusrq_n), .fa(fa), .fa_sel(fa_sel), .frd_n(frd_n), .fwr_n(fwr_n),
    .fmrq_n(fmrq_n), .fiorq_n(fiorq_n), .forq_n(forq_n), .fd_o(fd_o), .fd_oe(fd_oe),
    .fd_i(fd_i), .owner(owner));

  always #10 clk50 = ~clk50;

  int n_cmp = 0, n_bad = 0;
  exp_t q0[$], q1[$];
  int ack_log[$];
  logic rr_model = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Device-side read data is a function of the full address seen on the bus.
  function automatic logic [7:0] rdfun(input logic [15:0] a);
    return a[15:8] ^ {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  // ---------------- CPLD / device model ----------------
  logic       cpld_en = 1'b1;
  int         cpld_dly = 4;
  logic [7:0] ahi = 8'h00;
  logic       fd_force_en = 1'b0;
  logic [7:0] fd_force = 8'h00;
  assign fd_i = fd_force_en ? fd_force : rdfun({ahi, fa});

  initial begin : cpld
    int bcnt;
    bcnt = 0;
    forever begin
      @(negedge clk50);
      if (fa_sel) ahi = fa;
      if (fbusrq_n) begin
        busak_n = 1'b1; bcnt = 0;
      end else if (cpld_en && busak_n) begin
        bcnt++;
        if (bcnt >= cpld_dly) busak_n = 1'b0;
      end
    end
  end

  // ---------------- Bus monitor / scoreboard ----------------
  logic       in_str = 1'b0, cap_io, cap_we, mix;
  logic [7:0] cap_hi, cap_lo, cap_wd;
  int         str_len = 0, brq_hi = 0;
  logic       sim_watch = 1'b0;

  initial begin : mon
    logic strb;
    int r;
    exp_t e;
    forever begin
      @(negedge clk50);
      if (rst) begin
        in_str = 1'b0; str_len = 0;
      end else begin
        strb = !fmrq_n || !fiorq_n || !frd_n || !fwr_n;
        if (fa_sel) cap_hi = fa;
        if (strb) begin
          if (!in_str) begin
            in_str = 1'b1; str_len = 0; mix = 1'b0;
            cap_lo = fa; cap_io = !fiorq_n; cap_we = !fwr_n; cap_wd = fd_o;
          end
          str_len++;
          if (((!fmrq_n) == (!fiorq_n)) || ((!frd_n) == (!fwr_n)) || ((!fiorq_n) != cap_io) ||
              ((!fwr_n) != cap_we) || (fa !== cap_lo) || fa_sel || (fd_oe != cap_we) ||
              (forq_n != !cap_we) || (fbusrq_n != 1'b0))
            mix = 1'b1;
        end else in_str = 1'b0;
        if (sim_watch && ack_log.size() > 0 && ack_log.size() < 6 && fbusrq_n) brq_hi++;
        if (ack0 || ack1) begin
          r = ack1 ? 1 : 0;
          chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
          if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ack actual=ack%0d required=none at %0t", r, $time);
          end else begin
            e = (r == 0) ? q0.pop_front() : q1.pop_front();
            chk("owner", 32'(owner), 32'(r));
            chk("err", 32'(err), 32'(e.err));
            if (e.err) chk("strobes_on_abort", 32'(str_len), 32'd0);
            else begin
              chk("bus_addr", {16'h0, cap_hi, cap_lo}, {16'h0, e.addr});
              chk("bus_io", 32'(cap_io), 32'(e.io));
              chk("bus_we", 32'(cap_we), 32'(e.we));
              chk("strobe_len", 32'(str_len), 32'(STROBE_CYC));
              chk("strobe_clean", 32'(mix), 32'd0);
              chk("recover_drive", {23'h0, forq_n, fd_o}, e.we ? {24'h0, e.wd} : {23'h0, 1'b1, 8'h00});
              if (e.we) chk("wdata", 32'(cap_wd), 32'(e.wd));
              else      chk("rdata", 32'(rdata), 32'(e.rd));
            end
          end
          ack_log.push_back(r);
          rr_model = (r == 0);
          str_len = 0;
        end
      end
    end
  end

  // ---------------- Requester stimulus ----------------
  task automatic set_req(input int r, input logic [15:0] a, input logic w, input logic i,
                         input logic [7:0] d, input logic e_err, input bit push);
    exp_t e;
    e.addr = a; e.we = w; e.io = i; e.wd = d; e.err = e_err;
    e.rd = fd_force_en ? fd_force : rdfun(a);
    addr_v[r] = a; we_v[r] = w; io_v[r] = i; wd_v[r] = d; req_v[r] = 1'b1;
    if (push) begin
      if (r == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic rand_req(input int r, input logic e_err);
    set_req(r, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom), e_err, 1'b1);
  endtask

  task automatic wait_ack(input int r, output int cyc, output int lo);
    bit done;
    done = 0; cyc = 0; lo = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk50);
      cyc++;
      if (!fbusrq_n) lo++;
      if (r == 1 ? ack1 : ack0) done = 1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_wait actual=no_ack required=ack%0d", r);
    end
  endtask

  task automatic run_req(input int r, input int n, input int maxgap);
    int g, c, l;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, maxgap);
      if (g > 0) begin
        req_v[r] = 1'b0;
        repeat (g) @(negedge clk50);
      end
      rand_req(r, 1'b0);
      wait_ack(r, c, l);
    end
    req_v[r] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && !(fbusrq_n && busak_n); k++) @(negedge clk50);
    repeat (4) @(negedge clk50);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int c, l, k;
    int expseq[6];
    addr_v[0] = '0; addr_v[1] = '0; wd_v[0] = '0; wd_v[1] = '0;
    #1;
    chk("rst_n_outs", {26'h0, fbusrq_n, frd_n, fwr_n, fmrq_n, fiorq_n, forq_n}, 32'h3F);
    chk("rst_fa", {23'h0, fa_sel, fa}, 32'h0);
    chk("rst_fd", {23'h0, fd_oe, fd_o}, 32'h0);
    chk("rst_ack", {21'h0, ack0, ack1, err, rdata}, 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    repeat (3) @(negedge clk50);
    rst = 1'b0;
    @(negedge clk50);

    // Memory read, CPLD acknowledges 10 clocks after the request.
    cpld_dly = 10; fd_force_en = 1'b1; fd_force = 8'hA5;
    set_req(0, 16'h5B12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    wait_ack(0, c, l);
    req_v[0] = 1'b0; fd_force_en = 1'b0;
    chk("idle_latency_lo", 32'(l), 32'(cpld_dly + 2 + 1 + ADDR_CYC + STROBE_CYC + 1));

    // I/O write from requester 1.
    cpld_dly = 3;
    set_req(1, 16'h00FE, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1);
    wait_ack(1, c, l);
    req_v[1] = 1'b0;

    // Acknowledge never arrives: abort with err after TMO_CYC clocks.
    wait_idle();
    cpld_en = 1'b0;
    rand_req(0, 1'b1);
    wait_ack(0, c, l);
    req_v[0] = 1'b0;
    chk("tmo_busrq_cycles", 32'(l), 32'(TMO_CYC));
    @(negedge clk50);
    chk("tmo_release", 32'(fbusrq_n), 32'd1);
    cpld_en = 1'b1;

    // Hold then release.
    wait_idle();
    rand_req(0, 1'b0);
    wait_ack(0, c, l);
    req_v[0] = 1'b0;
    k = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk50);
      k++;
      if (fbusrq_n) break;
    end
    chk("hold_release_cycles", 32'(k), 32'(HOLD_CYC + 1));

    // Request in the 10th HOLD clock goes straight to ADDR_H.
    wait_idle();
    rand_req(1, 1'b0);
    wait_ack(1, c, l);
    req_v[1] = 1'b0;
    repeat (10) @(negedge clk50);
    rand_req(0, 1'b0);
    wait_ack(0, c, l);
    req_v[0] = 1'b0;
    chk("hold_req_latency", 32'(c), 32'(ADDR_CYC + STROBE_CYC + 2));
    chk("hold_no_busrq", 32'(c - l), 32'd0);

    // Randomised concurrent traffic.
    for (int p = 0; p < 3; p++) begin
      cpld_dly = $urandom_range(1, 8);
      fork
        run_req(0, 8, 3);
        run_req(1, 8, 3);
      join
      wait_idle();
    end

    // Both requesters held continuously for 3 transfers each.
    ack_log.delete();
    brq_hi = 0;
    sim_watch = 1'b1;
    for (int i = 0; i < 6; i++)
      if (RR) expseq[i] = ((i % 2) == 0) ? int'(rr_model) : int'(!rr_model);
      else    expseq[i] = (i < 3) ? 0 : 1;
    fork
      run_req(0, 3, 0);
      run_req(1, 3, 0);
    join
    sim_watch = 1'b0;
    chk("sim_ack_count", 32'(ack_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < ack_log.size(); i++)
      chk($sformatf("sim_order_%0d", i), 32'(ack_log[i]), 32'(expseq[i]));
    chk("sim_busrq_held", 32'(brq_hi), 32'd0);
    wait_idle();

    // Reset in the middle of STROBE.
    set_req(0, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 100 && frd_n; i++) @(negedge clk50);
    repeat (3) @(negedge clk50);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {27'h0, fmrq_n, fiorq_n, frd_n, fwr_n, fbusrq_n}, 32'h1F);
    chk("rst_mid_ack", {29'h0, ack0, ack1, err}, 32'h0);
    req_v[0] = 1'b0;
    rr_model = 1'b0;
    @(negedge clk50);
    chk("rst_mid_ack_held", {29'h0, ack0, ack1, err}, 32'h0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk50);
      chk("post_rst_idle", {30'h0, fbusrq_n, ack0 | ack1}, 32'h2);
    end

    // Scoreboard must be drained.
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
